// File: rtl/intr_src_cond.sv
// Interrupt source conditioner: synchronises raw interrupt lines, applies
// per-source level or rising-edge capture, latches edge events as pending,
// tracks overruns and presents a masked pending vector to the interrupt
// controller. Configured and inspected through a zero-wait-state APB slave.
//
// APB handshake: a transfer is a setup cycle (psel_i=1, penable_i=0)
// followed by an access cycle (psel_i=1, penable_i=1). pready_o is high in
// every access cycle, so each access completes in one cycle. Writes commit on
// the clock edge that ends the access cycle; read data is combinational and
// driven whenever psel_i=1 and pwrite_i=0, and is 0 otherwise.
module intr_src_cond #(
    parameter int NUM_INTR = 16,
    parameter int ID_W     = 4
) (
    input  logic                pclk_i,
    input  logic                prst_n_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [3:0]          paddr_i,
    input  logic [NUM_INTR-1:0] pwdata_i,
    output logic [NUM_INTR-1:0] prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic [NUM_INTR-1:0] irq_raw_i,
    output logic [NUM_INTR-1:0] intr_active_o,
    input  logic                intr_serviced_i,
    input  logic [ID_W-1:0]     intr_serviced_id_i
);

    localparam logic [3:0] ADDR_ENABLE  = 4'h0;
    localparam logic [3:0] ADDR_MODE    = 4'h1;
    localparam logic [3:0] ADDR_PENDING = 4'h2;
    localparam logic [3:0] ADDR_RAW     = 4'h3;
    localparam logic [3:0] ADDR_ACTIVE  = 4'h4;
    localparam logic [3:0] ADDR_OVERRUN = 4'h5;

    // Three-stage chain: s1/s2 resolve metastability, s3 delays s2 for edge detection.
    logic [NUM_INTR-1:0] s1, s2, s3;
    logic [NUM_INTR-1:0] enable_q;
    logic [NUM_INTR-1:0] mode_q;      // 1 = rising edge, 0 = level
    logic [NUM_INTR-1:0] pending_q;
    logic [NUM_INTR-1:0] overrun_q;

    logic                apb_access;
    logic                wr_en;
    logic                wr_enable, wr_mode, wr_pending, wr_overrun;
    logic [NUM_INTR-1:0] edge_det;
    logic [NUM_INTR-1:0] svc_onehot;
    logic [NUM_INTR-1:0] edge_clr;
    logic [NUM_INTR-1:0] mode_chg;
    logic [NUM_INTR-1:0] edge_next;
    logic [NUM_INTR-1:0] pending_next;
    logic [NUM_INTR-1:0] overrun_set;
    logic [NUM_INTR-1:0] overrun_clr;
    logic [NUM_INTR-1:0] overrun_next;
    logic [NUM_INTR-1:0] rd_data;

    assign apb_access = psel_i & penable_i;
    assign wr_en      = apb_access & pwrite_i;
    assign wr_enable  = wr_en & (paddr_i == ADDR_ENABLE);
    assign wr_mode    = wr_en & (paddr_i == ADDR_MODE);
    assign wr_pending = wr_en & (paddr_i == ADDR_PENDING);
    assign wr_overrun = wr_en & (paddr_i == ADDR_OVERRUN);

    assign edge_det = s2 & ~s3;

    // Decode the service acknowledge into a per-source clear vector.
    always_comb begin
        svc_onehot = '0;
        if (intr_serviced_i) begin
            svc_onehot[intr_serviced_id_i] = 1'b1;
        end
    end

    // Edge bits: a new edge wins over any clear arriving on the same edge.
    assign edge_clr  = (wr_pending ? pwdata_i : '0) | svc_onehot;
    assign edge_next = edge_det | (pending_q & ~edge_clr);

    // A mode change flushes the affected pending bits; level bits resume tracking next edge.
    assign mode_chg     = wr_mode ? (pwdata_i ^ mode_q) : '0;
    assign pending_next = ((mode_q & edge_next) | (~mode_q & s2)) & ~mode_chg;

    // Overrun: a further edge on a source whose edge event is still pending.
    assign overrun_set  = mode_q & edge_det & pending_q;
    assign overrun_clr  = wr_overrun ? pwdata_i : '0;
    assign overrun_next = overrun_set | (overrun_q & ~overrun_clr);

    // Synchroniser chain for the asynchronous interrupt lines.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_raw_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Firmware-programmed configuration registers.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            enable_q <= '0;
            mode_q   <= '0;
        end else begin
            if (wr_enable) enable_q <= pwdata_i;
            if (wr_mode)   mode_q   <= pwdata_i;
        end
    end

    // Pending and overrun status state.
    always_ff @(posedge pclk_i or negedge prst_n_i) begin
        if (!prst_n_i) begin
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            pending_q <= pending_next;
            overrun_q <= overrun_next;
        end
    end

    // Register read multiplexer; unmapped indices read as zero.
    always_comb begin
        rd_data = '0;
        case (paddr_i)
            ADDR_ENABLE:  rd_data = enable_q;
            ADDR_MODE:    rd_data = mode_q;
            ADDR_PENDING: rd_data = pending_q;
            ADDR_RAW:     rd_data = s2;
            ADDR_ACTIVE:  rd_data = intr_active_o;
            ADDR_OVERRUN: rd_data = overrun_q;
            default:      rd_data = '0;
        endcase
    end

    // APB responses are forced low while reset is asserted.
    assign pready_o      = prst_n_i & apb_access;
    assign pslverr_o     = prst_n_i & apb_access & (paddr_i > ADDR_OVERRUN);
    assign prdata_o      = (prst_n_i & psel_i & ~pwrite_i) ? rd_data : '0;
    assign intr_active_o = pending_q & enable_q;

endmodule

// File: tb/tb_intr_src_cond.sv
// Self-checking bench for intr_src_cond: directed scenarios followed by a
// randomized phase, all checked against a per-source behavioural model.
module tb_intr_src_cond;

    logic        pclk = 1'b0;
    logic        prst_n = 1'b0;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [15:0] irq_raw = '0;
    logic [15:0] intr_active;
    logic        srv = 1'b0;
    logic [3:0]  srv_id = '0;

    int total = 0;
    int bad = 0;
    bit rand_on = 1'b0;

    intr_src_cond #(.NUM_INTR(16), .ID_W(4)) dut (
        .pclk_i(pclk), .prst_n_i(prst_n), .psel_i(psel), .penable_i(penable),
        .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
        .pready_o(pready), .pslverr_o(pslverr), .irq_raw_i(irq_raw),
        .intr_active_o(intr_active), .intr_serviced_i(srv),
        .intr_serviced_id_i(srv_id)
    );

    // clock
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // m_hist holds raw-line samples, oldest first: the line value seen by the
    // conditioner two edges ago decides levels, and a 0->1 step between the
    // samples three and two edges ago is a rising edge.
    logic [15:0] m_hist[$];
    bit m_en[16], m_mode[16], m_pend[16], m_ovr[16];

    function automatic void model_clear();
        m_hist = '{16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 16; i++) begin
            m_en[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
        end
    endfunction

    function automatic logic [15:0] pack(input bit v[16]);
        logic [15:0] r = '0;
        for (int i = 0; i < 16; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [15:0] model_active();
        return pack(m_pend) & pack(m_en);
    endfunction

    function automatic logic [15:0] model_read(input logic [3:0] a);
        case (a)
            4'h0: return pack(m_en);
            4'h1: return pack(m_mode);
            4'h2: return pack(m_pend);
            4'h3: return m_hist[1];
            4'h4: return model_active();
            4'h5: return pack(m_ovr);
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            model_clear();
        end else begin
            bit wr;
            logic [15:0] lvl, prev;
            wr   = psel && penable && pwrite;
            lvl  = m_hist[1];
            prev = m_hist[0];
            for (int i = 0; i < 16; i++) begin
                bit rose, cleared, changed, nxt;
                rose    = lvl[i] && !prev[i];
                changed = wr && paddr == 4'h1 && (pwdata[i] != m_mode[i]);
                if (!m_mode[i]) begin
                    nxt = lvl[i];
                end else begin
                    cleared = (wr && paddr == 4'h2 && pwdata[i]) || (srv && srv_id == i);
                    if (rose && m_pend[i]) m_ovr[i] = 1;
                    else if (wr && paddr == 4'h5 && pwdata[i]) m_ovr[i] = 0;
                    if (rose) nxt = 1;
                    else if (cleared) nxt = 0;
                    else nxt = m_pend[i];
                end
                if (!m_mode[i] && wr && paddr == 4'h5 && pwdata[i]) m_ovr[i] = 0;
                m_pend[i] = changed ? 0 : nxt;
                if (wr && paddr == 4'h0) m_en[i] = pwdata[i];
                if (wr && paddr == 4'h1) m_mode[i] = pwdata[i];
            end
            m_hist.push_back(irq_raw);
            void'(m_hist.pop_front());
        end
    end

    // active-vector monitor, sampled mid-cycle
    always @(negedge pclk) begin
        check("active_mon", intr_active, model_active());
    end

    // random line / acknowledge driver for the randomized phase
    always @(posedge pclk) begin
        if (rand_on) begin
            #1;
            for (int i = 0; i < 16; i++)
                if ($urandom_range(0, 9) == 0) irq_raw[i] = ~irq_raw[i];
            srv    = ($urandom_range(0, 3) == 0);
            srv_id = 4'($urandom_range(0, 15));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apb_write(input logic [3:0] a, input logic [15:0] d);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        check("wr_pready", {15'h0, pready}, 16'h1);
        check("wr_pslverr", {15'h0, pslverr}, {15'h0, a > 4'h5});
        @(posedge pclk); #1;
        psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [15:0] d,
                            output logic err, output logic [15:0] exp);
        @(posedge pclk); #1;
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge pclk); #1;
        penable = 1;
        @(negedge pclk);
        d = prdata; err = pslverr; exp = model_read(a);
        check("rd_pready", {15'h0, pready}, 16'h1);
        @(posedge pclk); #1;
        psel = 0; penable = 0;
    endtask

    task automatic read_expect(input string tag, input logic [3:0] a, input logic [15:0] want);
        logic [15:0] d, ex;
        logic err;
        apb_read(a, d, err, ex);
        check(tag, d, want);
        check({tag, "_model"}, d, ex);
    endtask

    task automatic pulse_line(input int idx);
        @(posedge pclk); #1 irq_raw[idx] = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #1 irq_raw[idx] = 1'b0;
        repeat (4) @(posedge pclk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] d, ex;
        logic err;
        int hi_cnt, first_hi;

        model_clear();
        repeat (3) @(posedge pclk);
        #2 prst_n = 1'b1;

        // reset values
        check("reset_active", intr_active, 16'h0);
        for (int a = 0; a < 6; a++) begin
            apb_read(4'(a), d, err, ex);
            check("reset_reg", d, 16'h0);
            check("reset_slverr", {15'h0, err}, 16'h0);
        end

        // edge capture on source 0, 3-cycle latency, then acknowledge
        apb_write(4'h0, 16'hFFFF);
        apb_write(4'h1, 16'h0001);
        @(posedge pclk); #1 irq_raw[0] = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #1 irq_raw[0] = 1'b0;
        @(negedge pclk) check("edge_before_e3", intr_active, 16'h0000);
        @(posedge pclk);
        @(negedge pclk) check("edge_at_e3", intr_active, 16'h0001);
        repeat (4) @(posedge pclk);
        @(negedge pclk) check("edge_sticky", intr_active, 16'h0001);
        @(posedge pclk); #1 srv = 1'b1; srv_id = 4'd0;
        @(posedge pclk); #1 srv = 1'b0;
        @(negedge pclk) check("edge_acked", intr_active, 16'h0000);

        // level source 5 held for 10 cycles
        apb_write(4'h1, 16'h0000);
        apb_write(4'h0, 16'h0020);
        hi_cnt = 0; first_hi = -1;
        @(posedge pclk); #1 irq_raw[5] = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge pclk);
            if (c == 10) #1 irq_raw[5] = 1'b0;
            @(negedge pclk);
            if (intr_active[5]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = c;
            end
        end
        check("level_hi_cycles", 16'(hi_cnt), 16'd10);
        check("level_first_hi", 16'(first_hi), 16'd3);
        @(posedge pclk); #1 irq_raw[5] = 1'b1;
        repeat (5) @(posedge pclk);
        apb_write(4'h2, 16'h0020);
        @(negedge pclk) check("level_w1c_ignored", intr_active, 16'h0020);
        @(posedge pclk); #1 irq_raw[5] = 1'b0;
        repeat (5) @(posedge pclk);

        // overrun on edge source 3
        apb_write(4'h0, 16'h0008);
        apb_write(4'h1, 16'h0008);
        pulse_line(3);
        pulse_line(3);
        read_expect("overrun_set", 4'h5, 16'h0008);
        apb_write(4'h5, 16'h0008);
        read_expect("overrun_clr", 4'h5, 16'h0000);

        // edge on 7 coincident with its acknowledge, source 7 disabled
        apb_write(4'h2, 16'h0008);
        apb_write(4'h1, 16'h0088);
        @(posedge pclk); #1 irq_raw[7] = 1'b1;
        @(posedge pclk);
        @(posedge pclk); #1 srv = 1'b1; srv_id = 4'd7;
        @(posedge pclk); #1 srv = 1'b0;
        read_expect("set_wins_pending", 4'h2, 16'h0080);
        check("set_wins_masked", intr_active, 16'h0000);
        irq_raw = '0;

        // unmapped read, then reset in the middle of the access
        apb_write(4'h0, 16'h0080);
        @(negedge pclk) check("pre_reset_active", intr_active, 16'h0080);
        @(posedge pclk); #1 psel = 1; penable = 0; pwrite = 0; paddr = 4'h9;
        @(posedge pclk); #1 penable = 1;
        @(negedge pclk);
        check("unmapped_pready", {15'h0, pready}, 16'h1);
        check("unmapped_slverr", {15'h0, pslverr}, 16'h1);
        check("unmapped_prdata", prdata, 16'h0);
        #1 prst_n = 1'b0;
        #1;
        check("rst_pready", {15'h0, pready}, 16'h0);
        check("rst_pslverr", {15'h0, pslverr}, 16'h0);
        check("rst_prdata", prdata, 16'h0);
        check("rst_active", intr_active, 16'h0);
        psel = 0; penable = 0;
        @(posedge pclk); #2 prst_n = 1'b1;

        // randomized phase
        apb_write(4'h0, 16'($urandom));
        apb_write(4'h1, 16'($urandom));
        rand_on = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) begin
                logic [15:0] wd;
                wd = 16'($urandom);
                if (a == 4'h1 && $urandom_range(0, 3) != 0) wd = model_read(4'h1);
                apb_write(a, wd);
            end else begin
                apb_read(a, d, err, ex);
                check("rand_rdata", d, ex);
                check("rand_slverr", {15'h0, err}, {15'h0, a > 4'h5});
            end
            repeat ($urandom_range(0, 3)) @(posedge pclk);
        end
        rand_on = 1'b0;
        @(posedge pclk); #1 srv = 1'b0; irq_raw = '0;
        repeat (6) @(posedge pclk);
        for (int a = 0; a < 6; a++) begin
            apb_read(4'(a), d, err, ex);
            check("final_reg", d, ex);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intr_src_cond.md
# intr_src_cond

Interrupt source conditioner that sits directly upstream of the 16-source priority interrupt controller and drives its `intr_active_i` vector. It synchronises raw peripheral interrupt lines into `pclk_i`, applies per-source level or rising-edge capture, latches edge events as pending, masks them with an enable register, and clears pending edge events on the controller's service acknowledge or by APB write-1-to-clear. Firmware programs and inspects it over a zero-wait-state APB slave port.

## Interface
- `NUM_INTR`, 16: number of sources. Fixed at 16 for register packing.
- `ID_W`, 4: width of the serviced-source index.

- `pclk_i`  in  1  clock
- `prst_n_i`  in  1  reset, asynchronous, active-low
- `psel_i`  in  1  APB select
- `penable_i`  in  1  APB enable (access phase)
- `pwrite_i`  in  1  1 = write, 0 = read
- `paddr_i`  in  4  word register index
- `pwdata_i`  in  16  write data
- `prdata_o`  out  16  read data
- `pready_o`  out  1  transfer complete
- `pslverr_o`  out  1  error for an unmapped address
- `irq_raw_i`  in  NUM_INTR  asynchronous peripheral interrupt lines
- `intr_active_o`  out  NUM_INTR  masked pending vector to the interrupt controller
- `intr_serviced_i`  in  1  one-cycle service acknowledge from the controller side
- `intr_serviced_id_i`  in  ID_W  index of the source being acknowledged

## Operation
- **Synchroniser:** per bit, `s1 <= irq_raw_i`, `s2 <= s1`, `s3 <= s2`. An edge is `s2 & ~s3`.
- **Registers** (`paddr_i`):
  - 0x0 ENABLE: RW.
  - 0x1 MODE: RW. 1 = rising edge, 0 = level.
  - 0x2 PENDING: R. Write-1-to-clear affects edge bits only.
  - 0x3 RAW: R, returns `s2`.
  - 0x4 ACTIVE: R, returns `intr_active_o`.
  - 0x5 OVERRUN: R, write-1-to-clear.
  - 0x6–0xF: unmapped.
- **Pending, level bits** (MODE=0): `pending[i] <= s2[i]` every cycle. Write-1-to-clear and service acknowledge are ignored.
- **Pending, edge bits** (MODE=1):
  - Set on edge.
  - Cleared by PENDING write-1-to-clear, or by `intr_serviced_i` with `intr_serviced_id_i==i`.
  - If set and clear happen on the same edge, set wins.
- **Overrun:** `overrun[i]` is set when an edge arrives while `pending[i]` is already 1 in edge mode, including the set-wins case above. It is sticky until written 1.
- **MODE write:** every bit whose mode changes has its pending cleared on that edge. Level bits then re-track `s2` from the next edge.
- **Output:** `intr_active_o = pending & ENABLE`. This is combinational from registers. A disabled source keeps its pending bit and reasserts when re-enabled.
- **APB:**
  - `pready_o = psel_i & penable_i`, combinational, so there are no wait states.
  - Writes commit on the edge where `psel_i & penable_i & pwrite_i`.
  - `prdata_o` is combinational and valid when `psel_i & ~pwrite_i`; otherwise it is 0.
  - `pslverr_o = psel_i & penable_i & (paddr_i > 5)`. Unmapped writes are dropped and unmapped reads return 0.
  - Writes to RAW and ACTIVE are ignored and return no error.
- **Reset:** asynchronous, `prst_n_i=0`. All flops go to 0: sync chain, ENABLE, MODE, PENDING, OVERRUN. Outputs during reset: `prdata_o=0`, `pready_o=0`, `pslverr_o=0`, `intr_active_o=0`.

## Timing
- **Input to output latency:** `irq_raw_i` is stable before edge E1. `s1` captures at E1, `s2` at E2, and `pending` updates at E3. `intr_active_o` is visible after E3, a 3-cycle latency for both modes.
- **Level deassertion:** follows the same 3-cycle path.
- **Acknowledge:** pending clears at the edge sampling `intr_serviced_i=1`, and `intr_active_o` drops in the following cycle.
- **ENABLE write:** takes effect on `intr_active_o` in the cycle after the write edge.
- **Line high at reset release:** because `s3` resets to 0, a line held high through reset release is detected as an edge 3 edges after release.
- **Reset mid-operation:** clears everything immediately, with no dependence on the clock. Any pending APB transfer is lost.
- **Glitches:** a pulse shorter than one `pclk_i` period may be missed. That is acceptable and is not required to be detected.

## Test plan
- Reset with all lines 0, then read registers 0x0–0x5 -> all return 0x0000, `pslverr_o=0`.
- Write ENABLE=0xFFFF, MODE=0x0001, pulse `irq_raw_i[0]` high for 2 cycles -> `intr_active_o=0x0001` from E3. It stays set after the line drops. `intr_serviced_i` with id=0 -> `intr_active_o=0x0000` next cycle.
- MODE=0, ENABLE=0x0020, hold `irq_raw_i[5]` high for 10 cycles -> `intr_active_o[5]` is high for exactly 10 cycles, delayed by 3. A write of 0x0020 to PENDING has no effect.
- Edge source 3 pending, second rising edge on line 3 before acknowledge -> OVERRUN reads 0x0008. Writing 0x0008 to 0x5 -> reads 0x0000.
- Edge on line 7 at the same edge as `intr_serviced_i` id=7 -> PENDING[7] stays 1. With ENABLE[7]=0, PENDING reads 0x0080 and `intr_active_o[7]=0`.
- APB read of 0x9 -> `pready_o=1`, `pslverr_o=1`, `prdata_o=0`. Assert `prst_n_i` low mid-transfer -> all outputs 0 immediately.
